// File: rtl/median_bisect_ctrl.sv
// median_bisect_ctrl: bisection controller that finds the MEDIAN_POS-th smallest 8-bit pixel of a window
// Ports: clock/reset (async, active-low); en starts a window from idle or chains one from emit;
// cfg_pivot/cfg_pivot_wr/cfg_pivot_full issue pivots to the counting stage;
// res_count/res_count_rd/res_count_empty take back first-word-fall-through counts of pixels <= pivot;
// median/median_wr/median_full emit one result per window; iter_count, busy and sticky err_count report status.
module median_bisect_ctrl #(
    parameter int MEDIAN_POS    = 512,
    parameter int BUFF_SIZE     = 1024,
    parameter int BUFF_SIZE_BIT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    output logic [7:0]               cfg_pivot,
    output logic                     cfg_pivot_wr,
    input  logic                     cfg_pivot_full,
    input  logic [BUFF_SIZE_BIT-1:0] res_count,
    output logic                     res_count_rd,
    input  logic                     res_count_empty,
    output logic [7:0]               median,
    output logic                     median_wr,
    input  logic                     median_full,
    output logic [3:0]               iter_count,
    output logic                     busy,
    output logic                     err_count
);
    localparam logic [BUFF_SIZE_BIT-1:0] MPOS  = BUFF_SIZE_BIT'(MEDIAN_POS);
    localparam logic [BUFF_SIZE_BIT-1:0] BSIZE = BUFF_SIZE_BIT'(BUFF_SIZE);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_EMIT} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               lo_q, lo_d, hi_q, hi_d, pivot_q, pivot_d, median_q, median_d;
    logic [3:0]               it_q, it_d, iter_q, iter_d;
    logic [BUFF_SIZE_BIT-1:0] count_q, count_d;
    logic                     err_q, err_d;
    logic                     ge, start;
    logic [7:0]               lo_n, hi_n;
    logic [8:0]               sum;

    always_comb begin
        ge    = count_q >= MPOS;
        lo_n  = ge ? lo_q : pivot_q + 8'd1;
        hi_n  = ge ? pivot_q : hi_q;
        sum   = {1'b0, lo_n} + {1'b0, hi_n};
        start = en && (state_q == S_IDLE || (state_q == S_EMIT && !median_full));
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        it_d         = it_q;
        pivot_d      = pivot_q;
        median_d     = median_q;
        iter_d       = iter_q;
        count_d      = count_q;
        err_d        = err_q;
        cfg_pivot_wr = 1'b0;
        res_count_rd = 1'b0;
        median_wr    = 1'b0;
        case (state_q)
            S_ISSUE: begin
                cfg_pivot_wr = !cfg_pivot_full;
                it_d         = cfg_pivot_full ? it_q : it_q + 4'd1;
                state_d      = cfg_pivot_full ? S_ISSUE : S_WAIT;
            end
            S_WAIT: begin
                res_count_rd = !res_count_empty;
                count_d      = res_count_empty ? count_q : res_count;
                state_d      = res_count_empty ? S_WAIT : S_UPDATE;
            end
            S_UPDATE: begin
                lo_d     = lo_n;
                hi_d     = hi_n;
                err_d    = err_q || (count_q > BSIZE);
                median_d = (lo_n == hi_n) ? lo_n : median_q;
                iter_d   = (lo_n == hi_n) ? it_q : iter_q;
                pivot_d  = (lo_n == hi_n) ? pivot_q : sum[8:1];
                state_d  = (lo_n == hi_n) ? S_EMIT : S_ISSUE;
            end
            S_EMIT: begin
                median_wr = !median_full;
                state_d   = median_full ? S_EMIT : S_IDLE;
            end
            default: state_d = state_q;
        endcase
        // Both idle start and chained restart after an emit share this initialisation.
        if (start) begin
            lo_d    = 8'd0;
            hi_d    = 8'd255;
            it_d    = 4'd0;
            pivot_d = 8'd127;
            state_d = S_ISSUE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            lo_q     <= 8'd0;
            hi_q     <= 8'd255;
            it_q     <= 4'd0;
            pivot_q  <= 8'd0;
            median_q <= 8'd0;
            iter_q   <= 4'd0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            it_q     <= it_d;
            pivot_q  <= pivot_d;
            median_q <= median_d;
            iter_q   <= iter_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign cfg_pivot  = pivot_q;
    assign median     = median_q;
    assign iter_count = iter_q;
    assign busy       = state_q != S_IDLE;
    assign err_count  = err_q;
endmodule

// File: tb/tb_median_bisect_ctrl.sv
// tb_median_bisect_ctrl: scoreboard bench for median_bisect_ctrl with a uniform-window counting-stage model
module tb_median_bisect_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  cfg_pivot;
    logic        cfg_pivot_wr;
    logic        cfg_pivot_full = 1'b0;
    logic [15:0] res_count;
    logic        res_count_rd;
    logic        res_count_empty;
    logic [7:0]  median;
    logic        median_wr;
    logic        median_full = 1'b0;
    logic [3:0]  iter_count;
    logic        busy;
    logic        err_count;

    int n_assert = 0;
    int n_fail = 0;

    logic [7:0]  exp_piv[$];
    logic [7:0]  exp_med[$];

    logic [7:0]  pix = 8'd0;
    logic        hold_empty = 1'b0;
    logic [15:0] cmem[16];
    int          wp = 0;
    int          rp = 0;
    int          push_n = 0;
    int          err_at = -1;

    logic [7:0] piv127[8] = '{8'd127, 8'd63, 8'd95, 8'd111, 8'd119, 8'd123, 8'd125, 8'd126};
    logic [7:0] piv0[8]   = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
    logic [7:0] piv255[8] = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254};

    median_bisect_ctrl dut (
        .clock(clock), .reset(reset), .en(en),
        .cfg_pivot(cfg_pivot), .cfg_pivot_wr(cfg_pivot_wr), .cfg_pivot_full(cfg_pivot_full),
        .res_count(res_count), .res_count_rd(res_count_rd), .res_count_empty(res_count_empty),
        .median(median), .median_wr(median_wr), .median_full(median_full),
        .iter_count(iter_count), .busy(busy), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Counting stage: every pixel of the window equals pix, so the count is all-or-nothing.
    always @(posedge clock) begin
        if (!reset) begin
            wp <= 0;
            rp <= 0;
        end else begin
            if (cfg_pivot_wr) begin
                cmem[wp[3:0]] <= (push_n == err_at) ? 16'd2000 : ((cfg_pivot >= pix) ? 16'd1024 : 16'd0);
                wp            <= wp + 1;
                push_n        <= push_n + 1;
            end
            if (res_count_rd) rp <= rp + 1;
        end
    end

    assign res_count       = cmem[rp[3:0]];
    assign res_count_empty = hold_empty || (wp == rp);

    always @(negedge clock) begin
        if (cfg_pivot_wr) begin
            if (exp_piv.size() == 0) chk("unexpected_pivot_wr", int'(cfg_pivot), -1);
            else chk("pivot", int'(cfg_pivot), int'(exp_piv.pop_front()));
        end
        if (median_wr) begin
            if (exp_med.size() == 0) chk("unexpected_median_wr", int'(median), -1);
            else chk("median", int'(median), int'(exp_med.pop_front()));
            chk("iter_count", int'(iter_count), 8);
        end
        if (cfg_pivot_wr || res_count_rd || median_wr) begin
            chk("strobe_onehot", int'(cfg_pivot_wr) + int'(res_count_rd) + int'(median_wr), 1);
            chk("strobe_blocked", int'((cfg_pivot_wr & cfg_pivot_full) | (res_count_rd & res_count_empty)
                                       | (median_wr & median_full)), 0);
        end
    end

    task automatic push_exp(input logic [7:0] p);
        for (int i = 0; i < 8; i++)
            exp_piv.push_back(p == 8'd0 ? piv0[i] : (p == 8'd255 ? piv255[i] : piv127[i]));
        exp_med.push_back(p);
    endtask

    // One window: f/e/m are stall lengths on pivot-full, count-empty and median-full.
    task automatic run_window(input logic [7:0] p, input int f, input int e, input int m,
                              input logic keep_en, input logic chained);
        bit done = 0;
        int n;
        pix = p;
        push_exp(p);
        cfg_pivot_full = (f > 0);
        hold_empty     = (e > 0);
        median_full    = (m > 0);
        if (!chained) begin
            @(posedge clock); #1;
            en = 1'b1;
        end
        for (n = 1; n <= 300 && !done; n++) begin
            @(posedge clock); #1;
            if (n == 1) en = keep_en;
            cfg_pivot_full = (n <= f);
            hold_empty     = (e > 0) && (n <= f + e + 1);
            median_full    = (m > 0) && (n < 25 + f + e + m);
            #1;
            if (n == 1 && chained) chk("chain_first_pivot_wr", int'(cfg_pivot_wr), 1);
            if (cfg_pivot_full) chk("pivot_stable", int'(cfg_pivot), 127);
            if (hold_empty && n > f + 1) chk("no_rd_while_empty", int'(res_count_rd), 0);
            if (median_wr) begin
                done = 1;
                chk("window_cycles", n, 25 + f + e + m);
            end
        end
        if (!done) chk("median_timeout", 0, 1);
        if (!keep_en) begin
            @(posedge clock); #1;
            chk("busy_after_emit", int'(busy), 0);
        end
    endtask

    task automatic abort_window();
        pix = 8'd127;
        for (int i = 0; i < 4; i++) exp_piv.push_back(piv127[i]);
        @(posedge clock); #1;
        en = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(posedge clock); #1;
            en = 1'b0;
        end
        chk("abort_in_wait_rd", int'(res_count_rd), 1);
        reset = 1'b0;
        #1;
        chk("abort_cfg_pivot", int'(cfg_pivot), 0);
        chk("abort_strobes", int'(cfg_pivot_wr) + int'(res_count_rd) + int'(median_wr), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_median", int'(median), 0);
        chk("abort_iter_count", int'(iter_count), 0);
        chk("abort_err_count", int'(err_count), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #2;
        chk("rst_cfg_pivot", int'(cfg_pivot), 0);
        chk("rst_median", int'(median), 0);
        chk("rst_iter_count", int'(iter_count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_strobes", int'(cfg_pivot_wr) + int'(res_count_rd) + int'(median_wr), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        run_window(8'd127, 0, 0, 0, 1'b0, 1'b0);
        chk("iter_count_hold", int'(iter_count), 8);
        run_window(8'd0, 0, 0, 0, 1'b0, 1'b0);
        run_window(8'd255, 0, 0, 0, 1'b0, 1'b0);
        run_window(8'd127, 5, 7, 0, 1'b0, 1'b0);
        run_window(8'd0, 0, 0, 10, 1'b1, 1'b0);
        run_window(8'd255, 0, 0, 0, 1'b0, 1'b1);
        chk("err_before_inject", int'(err_count), 0);
        err_at = push_n;
        run_window(8'd127, 0, 0, 0, 1'b0, 1'b0);
        chk("err_set", int'(err_count), 1);
        err_at = -1;
        run_window(8'd0, 0, 0, 0, 1'b0, 1'b0);
        chk("err_sticky", int'(err_count), 1);
        abort_window();
        run_window(8'd127, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        chk("pivot_queue_drained", exp_piv.size(), 0);
        chk("median_queue_drained", exp_med.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
